// File: rtl/nts_api_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nts_api_host_bridge
// Purpose  : Host-side front end for the NTS register API dispatcher.
//            Turns a four-phase req/ack host handshake into a single-cycle
//            API strobe, waits for the dispatcher response (or times out)
//            and returns data and status to the host. One transaction at
//            a time.
// Revision : 1.0 - initial release
// ============================================================================
module nts_api_host_bridge #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
   input  logic        i_clk,
   input  logic        i_areset_n,
   // host side
   input  logic        i_host_req,
   input  logic        i_host_we,
   input  logic [11:0] i_host_address,
   input  logic [31:0] i_host_write_data,
   output logic        o_host_ack,
   output logic [31:0] o_host_read_data,
   output logic        o_host_error,
   // dispatcher side
   output logic        o_api_cs,
   output logic        o_api_we,
   output logic [11:0] o_api_address,
   output logic [31:0] o_api_write_data,
   input  logic        i_api_busy,
   input  logic [31:0] i_api_read_data,
   input  logic        i_api_read_data_valid,
   // status
   output logic [15:0] o_timeout_count
);

   // Last WAIT cycle index before the transaction is declared dead.
   localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t      r_state;
   logic [7:0]  r_wait_cnt;
   logic        r_cs;
   logic        r_we;
   logic [11:0] r_address;
   logic [31:0] r_write_data;
   logic        r_ack;
   logic [31:0] r_read_data;
   logic        r_error;
   logic [15:0] r_timeout_count;

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state         <= ST_IDLE;
         r_wait_cnt      <= 8'd0;
         r_cs            <= 1'b0;
         r_we            <= 1'b0;
         r_address       <= 12'd0;
         r_write_data    <= 32'd0;
         r_ack           <= 1'b0;
         r_read_data     <= 32'd0;
         r_error         <= 1'b0;
         r_timeout_count <= 16'd0;
      end else begin
         // The strobe only lives for the single ISSUE cycle.
         r_cs <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Holding off while busy keeps a stale response from being
               // matched to the next transaction.
               if (i_host_req && !i_api_busy) begin
                  r_we         <= i_host_we;
                  r_address    <= i_host_address;
                  r_write_data <= i_host_write_data;
                  r_cs         <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wait_cnt <= 8'd0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
               // A response on the final cycle still beats the timeout.
               if (i_api_read_data_valid) begin
                  r_read_data <= r_we ? 32'd0 : i_api_read_data;
                  r_error     <= 1'b0;
                  r_ack       <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (r_wait_cnt == c_WAIT_LAST) begin
                  r_read_data <= r_we ? 32'd0 : ERROR_DATA;
                  r_error     <= 1'b1;
                  r_ack       <= 1'b1;
                  r_state     <= ST_RESP;
                  if (r_timeout_count != 16'hFFFF) begin
                     r_timeout_count <= r_timeout_count + 16'd1;
                  end
               end
            end
            ST_RESP: begin
               // Ack is held until the host withdraws its request.
               if (!i_host_req) begin
                  r_ack       <= 1'b0;
                  r_read_data <= 32'd0;
                  r_error     <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_api_cs         = r_cs;
   assign o_api_we         = r_we;
   assign o_api_address    = r_address;
   assign o_api_write_data = r_write_data;
   assign o_host_ack       = r_ack;
   assign o_host_read_data = r_read_data;
   assign o_host_error     = r_error;
   assign o_timeout_count  = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_nts_api_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nts_api_host_bridge
// Purpose  : Self-checking bench for nts_api_host_bridge. Acts as host and
//            as a dispatcher whose response latency is chosen per
//            transaction; expected timing and data come from the
//            handshake rules expressed as cycle arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nts_api_host_bridge;

   localparam int          c_TO  = 16;
   localparam logic [31:0] c_ERR = 32'hDEAD_BEEF;
   localparam int          c_NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [11:0] addr = 12'd0;
   logic [31:0] wdata = 32'd0;
   logic        busy = 1'b0;
   logic [31:0] api_rd = 32'd0;
   logic        api_v = 1'b0;

   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_err;
   logic        w_cs;
   logic        w_api_we;
   logic [11:0] w_api_addr;
   logic [31:0] w_api_wdata;
   logic [15:0] w_to_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_to  = 0;

   nts_api_host_bridge #(
      .TIMEOUT_CYCLES (c_TO),
      .ERROR_DATA     (c_ERR)
   ) u_dut (
      .i_clk                 (clk),
      .i_areset_n            (rst_n),
      .i_host_req            (req),
      .i_host_we             (we),
      .i_host_address        (addr),
      .i_host_write_data     (wdata),
      .o_host_ack            (w_ack),
      .o_host_read_data      (w_rdata),
      .o_host_error          (w_err),
      .o_api_cs              (w_cs),
      .o_api_we              (w_api_we),
      .o_api_address         (w_api_addr),
      .o_api_write_data      (w_api_wdata),
      .i_api_busy            (busy),
      .i_api_read_data       (api_rd),
      .i_api_read_data_valid (api_v),
      .o_timeout_count       (w_to_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Host outputs all zero while idle.
   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ack"},   32'(w_ack),   32'd0);
      check_eq({tag, "_rdata"}, w_rdata,      32'd0);
      check_eq({tag, "_err"},   32'(w_err),   32'd0);
      check_eq({tag, "_cs"},    32'(w_cs),    32'd0);
   endtask

   // One host transaction. Index 0 is the negedge where req is raised.
   // Busy stays high for nbusy cycles, the strobe follows one cycle after
   // busy clears, the dispatcher answers lat cycles after the strobe, and
   // ack shows up one cycle after the answer (or after c_TO wait cycles).
   task automatic run_txn(input logic t_we, input logic [11:0] t_addr,
                          input logic [31:0] t_wd, input logic [31:0] t_rd,
                          input int lat, input int nbusy, input int hold);
      int          cs_idx;
      int          cs_cnt;
      int          ack_idx;
      int          exp_ack;
      logic        exp_err;
      logic [31:0] exp_rd;
      cs_idx  = -1;
      cs_cnt  = 0;
      ack_idx = -1;
      exp_err = (lat > c_TO);
      exp_rd  = t_we ? 32'd0 : (exp_err ? c_ERR : t_rd);
      exp_ack = nbusy + 2 + (exp_err ? c_TO : lat);
      if (exp_err && exp_to < 65535) exp_to++;

      @(negedge clk);
      req   = 1'b1;
      we    = t_we;
      addr  = t_addr;
      wdata = t_wd;
      busy  = (nbusy > 0);
      api_v = 1'b0;
      for (int idx = 1; idx <= 200 && ack_idx < 0; idx++) begin
         @(negedge clk);
         if (w_cs) begin
            cs_cnt++;
            if (cs_idx < 0) cs_idx = idx;
            check_eq("cs_we",    32'(w_api_we),   32'(t_we));
            check_eq("cs_addr",  32'(w_api_addr), 32'(t_addr));
            if (t_we) check_eq("cs_wdata", w_api_wdata, t_wd);
         end
         if (w_ack) ack_idx = idx;
         busy   = (idx < nbusy);
         api_v  = (cs_idx >= 0) && (idx == cs_idx + lat);
         api_rd = api_v ? t_rd : $urandom;
      end
      check_eq("cs_count",  32'(cs_cnt),  32'd1);
      check_eq("cs_cycle",  32'(cs_idx),  32'(nbusy + 1));
      check_eq("ack_cycle", 32'(ack_idx), 32'(exp_ack));
      check_eq("rdata",     w_rdata,      exp_rd);
      check_eq("error",     32'(w_err),   32'(exp_err));
      check_eq("to_count",  32'(w_to_cnt), 32'(exp_to));

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         api_v = 1'b0;
         check_eq("hold_ack",   32'(w_ack), 32'd1);
         check_eq("hold_rdata", w_rdata,    exp_rd);
         check_eq("hold_cs",    32'(w_cs),  32'd0);
      end
      @(negedge clk);
      api_v = 1'b0;
      req   = 1'b0;
      @(negedge clk);
      check_idle_outputs("drop");
   endtask

   // A response pulse arriving while nothing is outstanding.
   task automatic stray_valid();
      @(negedge clk);
      api_v  = 1'b1;
      api_rd = $urandom;
      @(negedge clk);
      api_v = 1'b0;
      check_idle_outputs("stray1");
      @(negedge clk);
      check_idle_outputs("stray2");
      check_eq("stray_to_count", 32'(w_to_cnt), 32'(exp_to));
   endtask

   initial begin
      logic [11:0] b2b_addr [3];
      logic [31:0] v;
      int          seen;

      // reset state
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      check_eq("reset_to_count", 32'(w_to_cnt),   32'd0);
      check_eq("reset_api_addr", 32'(w_api_addr), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // normal read, write
      run_txn(1'b0, 12'h011, 32'h0, 32'h1234_5678, 4, 0, 0);
      run_txn(1'b1, 12'h085, 32'hCAFE_F00D, 32'h5555_AAAA, 4, 0, 1);
      // read timeout followed by a late response
      run_txn(1'b0, 12'h123, 32'h0, 32'h0BAD_0BAD, c_NEVER, 0, 0);
      stray_valid();
      // busy hold-off for 10 cycles
      run_txn(1'b0, 12'h3A5, 32'h0, 32'h0F0F_1234, 4, 10, 0);
      // response on the very last wait cycle wins over the timeout
      run_txn(1'b0, 12'h7FF, 32'h0, 32'hA5A5_5A5A, c_TO, 0, 0);
      // response one cycle too late is a timeout; write timeout returns 0
      run_txn(1'b0, 12'h456, 32'h0, 32'h1111_2222, c_TO + 1, 0, 0);
      run_txn(1'b1, 12'hABC, 32'h7777_8888, 32'h9999_0000, c_NEVER, 0, 2);

      // asynchronous reset during WAIT
      check_eq("pre_reset_to_count", 32'(w_to_cnt), 32'(exp_to));
      @(negedge clk);
      req  = 1'b1;
      we   = 1'b0;
      addr = 12'h0EE;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (w_cs) seen = 1;
      end
      check_eq("rst_cs_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      check_eq("async_rst_to_count", 32'(w_to_cnt),   32'd0);
      check_eq("async_rst_api_addr", 32'(w_api_addr), 32'd0);
      exp_to = 0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(1'b0, 12'h0EE, 32'h0, 32'hFEED_FACE, 4, 0, 0);

      // back-to-back reads
      b2b_addr[0] = 12'h000;
      b2b_addr[1] = 12'h020;
      b2b_addr[2] = 12'h200;
      for (int k = 0; k < 3; k++) begin
         v = {b2b_addr[k], 20'h0_0C0 + 20'(k)};
         run_txn(1'b0, b2b_addr[k], 32'h0, v, 4, 0, 0);
      end

      // randomized mix
      for (int k = 0; k < 30; k++) begin
         run_txn(1'($urandom_range(0, 1)), 12'($urandom), $urandom, $urandom,
                 $urandom_range(1, c_TO + 4), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
